// File: rtl/el_scan_driver.sv
// Dual-scan EL panel driver: reads upper and lower GRAM halves in lockstep and
// streams 4-pixel nibbles with VCLK/HS/VS strobes to the panel connector.
module el_scan_driver #(
   parameter int X_RES       = 640,
   parameter int HALF_LINES  = 200,
   parameter int BUS_W       = 4,
   parameter int RAM_LAT     = 1,
   parameter int HBLANK_CLKS = 16,
   parameter int HS_W        = 8
) (
   input  logic                                  pclk,
   input  logic                                  rst,
   input  logic                                  en,
   output logic                                  rden,
   output logic [$clog2(X_RES*HALF_LINES)-1:0]   rd_addr,
   input  logic                                  ram1_dat,
   input  logic                                  ram2_dat,
   output logic [BUS_W-1:0]                      el_ud,
   output logic [BUS_W-1:0]                      el_ld,
   output logic                                  el_vclk,
   output logic                                  el_hs,
   output logic                                  el_vs,
   output logic                                  frame_done
);

   localparam int AW = $clog2(X_RES*HALF_LINES);
   localparam int CW = $clog2(X_RES+RAM_LAT+4+HBLANK_CLKS);
   localparam int RW = $clog2(HALF_LINES+1);

   localparam logic [CW-1:0] C_RD_LAST  = CW'(X_RES-1);
   localparam logic [CW-1:0] C_ACT_LAST = CW'(X_RES+RAM_LAT+3);
   localparam logic [CW-1:0] C_HB_LAST  = CW'(HBLANK_CLKS-1);
   localparam logic [CW-1:0] C_SH_FIRST = CW'(RAM_LAT);
   localparam logic [CW-1:0] C_SH_LAST  = CW'(X_RES+RAM_LAT-1);
   localparam logic [CW-1:0] C_LD_FIRST = CW'(RAM_LAT+3);
   localparam logic [CW-1:0] C_VC_FIRST = CW'(RAM_LAT+4);
   localparam logic [CW-1:0] C_HS_END   = CW'(HS_W);
   localparam logic [RW-1:0] ROW_LAST   = RW'(HALF_LINES-1);
   localparam logic [AW-1:0] X_STEP     = AW'(X_RES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_HBLANK = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    c_q, c_d;
   logic [RW-1:0]    row_q, row_d;
   logic [AW-1:0]    base_q, base_d;
   logic [BUS_W-2:0] sh1_q, sh1_d, sh2_q, sh2_d;
   logic             rden_q, rden_d;
   logic [AW-1:0]    rd_addr_q, rd_addr_d;
   logic [BUS_W-1:0] ud_q, ud_d, ld_q, ld_d;
   logic             vclk_q, vclk_d, hs_q, hs_d, vs_q, vs_d, fd_q, fd_d;
   logic [1:0]       vphase, lphase;
   logic             shift_en, load_en;

   // Scan sequencing: state, column counter, row and row base address.
   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      row_d   = row_q;
      base_d  = base_q;
      case (state_q)
         S_IDLE: begin
            c_d    = '0;
            row_d  = '0;
            base_d = '0;
            if (en) state_d = S_ACTIVE;
            else    state_d = S_IDLE;
         end
         S_ACTIVE: begin
            if (c_q == C_ACT_LAST) begin
               state_d = S_HBLANK;
               c_d     = '0;
            end else begin
               state_d = S_ACTIVE;
               c_d     = c_q + CW'(1);
            end
         end
         S_HBLANK: begin
            if (c_q != C_HB_LAST) begin
               c_d = c_q + CW'(1);
            end else if (row_q != ROW_LAST) begin
               c_d     = '0;
               row_d   = row_q + RW'(1);
               base_d  = base_q + X_STEP;
               state_d = S_ACTIVE;
            end else begin
               // Frame end is the only point where a low en stops the scan.
               c_d     = '0;
               row_d   = '0;
               base_d  = '0;
               state_d = en ? S_ACTIVE : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            c_d     = '0;
            row_d   = '0;
            base_d  = '0;
         end
      endcase
   end

   // Panel-side outputs, derived from the next scan position so they register in step with it.
   always_comb begin
      vphase   = 2'(c_d - C_VC_FIRST);
      lphase   = 2'(c_q - C_LD_FIRST);
      shift_en = (state_q == S_ACTIVE) && (c_q >= C_SH_FIRST) && (c_q <= C_SH_LAST);
      load_en  = (state_q == S_ACTIVE) && (c_q >= C_LD_FIRST) && (c_q <= C_SH_LAST) && (lphase == 2'b00);
      rden_d    = 1'b0;
      rd_addr_d = '0;
      sh1_d     = '0;
      sh2_d     = '0;
      ud_d      = '0;
      ld_d      = '0;
      vclk_d    = 1'b0;
      hs_d      = 1'b0;
      vs_d      = 1'b0;
      fd_d      = 1'b0;
      if (state_d != S_IDLE) begin
         rden_d    = (state_d == S_ACTIVE) && (c_d <= C_RD_LAST);
         rd_addr_d = rden_d ? (base_d + AW'(c_d)) : rd_addr_q;
         sh1_d     = shift_en ? {sh1_q[BUS_W-3:0], ram1_dat} : sh1_q;
         sh2_d     = shift_en ? {sh2_q[BUS_W-3:0], ram2_dat} : sh2_q;
         ud_d      = load_en ? {sh1_q, ram1_dat} : ud_q;
         ld_d      = load_en ? {sh2_q, ram2_dat} : ld_q;
         vclk_d    = (state_d == S_ACTIVE) && (c_d >= C_VC_FIRST) && (vphase < 2'd2);
         hs_d      = (state_d == S_HBLANK) && (c_d < C_HS_END);
         vs_d      = (row_d == '0);
         fd_d      = (state_d == S_HBLANK) && (c_d == C_HB_LAST) && (row_d == ROW_LAST);
      end else begin
         rden_d = 1'b0;
      end
   end

   // All state and output registers with synchronous reset.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         c_q       <= '0;
         row_q     <= '0;
         base_q    <= '0;
         sh1_q     <= '0;
         sh2_q     <= '0;
         rden_q    <= 1'b0;
         rd_addr_q <= '0;
         ud_q      <= '0;
         ld_q      <= '0;
         vclk_q    <= 1'b0;
         hs_q      <= 1'b0;
         vs_q      <= 1'b0;
         fd_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         c_q       <= c_d;
         row_q     <= row_d;
         base_q    <= base_d;
         sh1_q     <= sh1_d;
         sh2_q     <= sh2_d;
         rden_q    <= rden_d;
         rd_addr_q <= rd_addr_d;
         ud_q      <= ud_d;
         ld_q      <= ld_d;
         vclk_q    <= vclk_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         fd_q      <= fd_d;
      end
   end

   assign rden       = rden_q;
   assign rd_addr    = rd_addr_q;
   assign el_ud      = ud_q;
   assign el_ld      = ld_q;
   assign el_vclk    = vclk_q;
   assign el_hs      = hs_q;
   assign el_vs      = vs_q;
   assign frame_done = fd_q;

endmodule
